// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for the RV32M radix-8 Booth multiplier.
// Takes MUL/MULH/MULHSU/MULHU requests over valid/ready. It extends the operands
// to XLEN+1 bits and holds them for MUL_CYCLES cycles. It then captures the
// selected product half into a response register.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake (req_ready is combinational)
//   req_funct3, req_rs1/2, req_rd   operation, operands, destination tag
//   flush                           pipeline kill, aborts any in-flight op
//   mul_a/mul_b/mul_hi/mul_en       drive to the Booth datapath
//   mul_result/mul_finish           datapath result and completion flag
//   resp_valid/resp_ready           response handshake
//   resp_data/resp_rd/resp_err      result, tag, error flag
//   busy                            controller not idle
module mult_seq_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic [XLEN:0]   mul_a,
    output logic [XLEN:0]   mul_b,
    output logic            mul_hi,
    output logic            mul_en,
    input  logic [XLEN-1:0] mul_result,
    input  logic            mul_finish,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_err,
    output logic            busy
);

    localparam int unsigned      CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_legal;
    logic             w_a_sext;
    logic             w_b_sext;
    logic [XLEN:0]    w_a_ext;
    logic [XLEN:0]    w_b_ext;

    // A new request may enter while idle, or while the current response is being consumed
    assign req_ready = !flush && ((r_state == ST_IDLE) || ((r_state == ST_RESP) && resp_ready));
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = !req_funct3[2];

    // A is unsigned only for MULHU; B is unsigned for MULHSU and MULHU
    assign w_a_sext  = (req_funct3[1:0] != 2'b11);
    assign w_b_sext  = !req_funct3[1];
    assign w_a_ext   = {w_a_sext & req_rs1[XLEN-1], req_rs1};
    assign w_b_ext   = {w_b_sext & req_rs2[XLEN-1], req_rs2};

    // Controller FSM with registered outputs; an accept overrides the RESP->IDLE exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_hi     <= 1'b0;
            mul_en     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_en     <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        resp_data  <= mul_result;
                        resp_err   <= !mul_finish;
                        resp_valid <= 1'b1;
                        mul_en     <= 1'b0;
                        mul_a      <= '0;
                        mul_b      <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            if (w_accept) begin
                busy    <= 1'b1;
                resp_rd <= req_rd;
                if (w_legal) begin
                    r_state <= ST_EXEC;
                    r_cnt   <= CNT_LOAD;
                    mul_en  <= 1'b1;
                    mul_a   <= w_a_ext;
                    mul_b   <= w_b_ext;
                    mul_hi  <= (req_funct3 != 3'b000);
                end else begin
                    // Illegal funct3 answers immediately and leaves the datapath idle
                    r_state    <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a directed vector table, hand-written
// corner sequences and randomized ops checked against a 64-bit arithmetic model.
module tb_mult_seq_ctrl;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 2;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [4:0]      req_rd;
    logic            flush;
    logic [XLEN:0]   mul_a;
    logic [XLEN:0]   mul_b;
    logic            mul_hi;
    logic            mul_en;
    logic [XLEN-1:0] mul_result;
    logic            mul_finish;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            resp_err;
    logic            busy;

    logic            finish_ok;

    mult_seq_ctrl #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_hi     (mul_hi),
        .mul_en     (mul_en),
        .mul_result (mul_result),
        .mul_finish (mul_finish),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in Booth datapath: 33x33 signed product of whatever the controller drives
    logic signed [65:0] w_pa, w_pb, w_prod;
    assign w_pa       = 66'($signed(mul_a));
    assign w_pb       = 66'($signed(mul_b));
    assign w_prod     = w_pa * w_pb;
    assign mul_result = mul_en ? (mul_hi ? w_prod[63:32] : w_prod[31:0]) : '0;
    assign mul_finish = mul_en & finish_ok;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: operands extended to 64 bits, low 64 bits of the product
    function automatic logic [63:0] op_a64(input logic [2:0] f3, input logic [31:0] a);
        return (f3 == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
    endfunction

    function automatic logic [63:0] op_b64(input logic [2:0] f3, input logic [31:0] b);
        return f3[1] ? {32'h0, b} : {{32{b[31]}}, b};
    endfunction

    function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] p;
        if (f3[2]) return 32'h0;
        p = op_a64(f3, a) * op_b64(f3, b);
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk_reset();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mul_en",     mul_en, 0);
        chk("rst_mul_ab",     {mul_a, mul_b}, 0);
        chk("rst_mul_hi",     mul_hi, 0);
        chk("rst_resp_data",  resp_data, 0);
        chk("rst_resp_rd",    resp_rd, 0);
        chk("rst_resp_err",   resp_err, 0);
        chk("rst_busy",       busy, 0);
        chk("rst_req_ready",  req_ready, 1);
    endtask

    // Entered and left at posedge+1; issues one op and consumes its response after 'hold' stall cycles
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [63:0] a64, b64;
        int          en_cycles;
        int          lat;
        bit          got;
        a64 = op_a64(f3, a);
        b64 = op_b64(f3, b);
        req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) chk("req_ready_timeout", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        en_cycles = 0;
        got       = 1'b0;
        for (lat = 0; lat < 16; lat++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            if (mul_en) begin
                en_cycles++;
                chk("exec_mul_a",  mul_a, a64[32:0]);
                chk("exec_mul_b",  mul_b, b64[32:0]);
                chk("exec_mul_hi", mul_hi, (f3 != 3'b000));
            end else begin
                chk("gated_mul_ab", {mul_a, mul_b}, 0);
            end
            @(posedge clk); #1;
        end
        chk("resp_timeout", got, 1);
        if (got) begin
            chk("latency",     lat, f3[2] ? 0 : MUL_CYCLES);
            chk("en_cycles",   en_cycles, f3[2] ? 0 : MUL_CYCLES);
            chk("resp_data",   resp_data, exp_d);
            chk("resp_err",    resp_err, exp_e);
            chk("resp_rd",     resp_rd, rd);
            chk("resp_busy",   busy, 1);
            chk("resp_mul_en", mul_en, 0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_data",  resp_data, exp_d);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("drain_valid", resp_valid, 0);
        chk("drain_busy",  busy, 0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        bit          got;

        tbl[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0};
        tbl[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0};
        tbl[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{3'b101, 32'h1234_5678, 32'h0000_0009, 5'd9,  32'h0000_0000, 1'b1};
        tbl[5] = '{3'b000, 32'h0000_0003, 32'h0000_0005, 5'd5,  32'h0000_000F, 1'b0};
        tbl[6] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd6,  32'h0000_0001, 1'b0};
        tbl[7] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd7,  32'hFFFF_FFFF, 1'b0};
        tbl[8] = '{3'b111, 32'h0000_0001, 32'h0000_0001, 5'd31, 32'h0000_0000, 1'b1};
        tbl[9] = '{3'b010, 32'h8000_0000, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; flush = 1'b0; resp_ready = 1'b0; finish_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 10; i++)
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, i % 3, tbl[i].exp_d, tbl[i].exp_e);

        // Backpressure with a queued request, then same-cycle handoff
        req_funct3 = 3'b000; req_rs1 = 32'd7; req_rs2 = 32'hFFFF_FFFD; req_rd = 5'd3;
        req_valid = 1'b1;
        #1;
        chk("bp_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_funct3 = 3'b011; req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'hFFFF_FFFF; req_rd = 5'd4;
        repeat (MUL_CYCLES) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_data",  resp_data, 32'hFFFF_FFEB);
            chk("bp_rd",    resp_rd, 3);
            chk("bp_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_handoff", req_ready, 1);
        @(posedge clk); #1;
        resp_ready = 1'b0; req_valid = 1'b0;
        chk("bp_busy_kept", busy, 1);
        chk("bp_mul_en",    mul_en, 1);
        chk("bp_valid_low", resp_valid, 0);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("bp2_got",  got, 1);
        chk("bp2_data", resp_data, 32'hFFFF_FFFE);
        chk("bp2_rd",   resp_rd, 4);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Flush on the first EXEC cycle
        req_funct3 = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd5; req_rd = 5'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("fl_in_exec", mul_en, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_busy",   busy, 0);
        chk("fl_mul_en", mul_en, 0);
        chk("fl_mul_ab", {mul_a, mul_b}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fl_no_resp", resp_valid, 0);
            @(posedge clk); #1;
        end
        run_op(3'b000, 32'd3, 32'd5, 5'd5, 0, 32'd15, 1'b0);

        // Flush beats a simultaneous accept
        req_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fl_blocks_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("fl_not_accepted", busy, 0);

        // Datapath not finished at capture
        finish_ok = 1'b0;
        run_op(3'b000, 32'd3, 32'd5, 5'd7, 0, 32'd15, 1'b1);
        finish_ok = 1'b1;

        // Reset while holding a response
        req_funct3 = 3'b001; req_rs1 = 32'h8000_0000; req_rs2 = 32'h8000_0000; req_rd = 5'd12;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rr_got_resp", got, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized ops against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            run_op(f3, a, b, rd, $urandom_range(0, 3), ref_data(f3, a, b), f3[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
